// File: rtl/enc83_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 8-to-3 request encoder.
package enc83_pkg;
  localparam int N_REQ  = 8;
  localparam int CODE_W = $clog2(N_REQ);

  typedef enum logic {IDLE, PRESENT} state_e;

  function automatic logic [N_REQ-1:0] onehot8(input logic [CODE_W-1:0] code);
    onehot8       = '0;
    onehot8[code] = 1'b1;
  endfunction
endpackage

// File: rtl/prio_find8.sv
// Combinational 8-way search starting at start_i, stepping down (DESCEND=1) or up with wrap.
module prio_find8 import enc83_pkg::*; #(
  parameter bit DESCEND = 1'b1
) (
  input  logic [N_REQ-1:0]  vec_i,
  input  logic [CODE_W-1:0] start_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              found_o
);
  logic [CODE_W-1:0] pos;

  // Walk farthest offset first so the nearest hit to start_i is the last write.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = DESCEND ? start_i - CODE_W'(k) : start_i + CODE_W'(k);
      if (vec_i[pos]) begin
        idx_o   = pos;
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/encoder83_req.sv
// Registered 8-to-3 request encoder with valid/ready presentation.
// Define ENC83_ROUND_ROBIN_EN for round-robin arbitration instead of highest-index priority.
module encoder83_req import enc83_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_REQ-1:0]  req_in,
  input  logic              ready_in,
  output logic [CODE_W-1:0] code_out,
  output logic              valid_out,
  output logic [N_REQ-1:0]  pending_out,
  output logic              overflow_out
);
  state_e            state_q, state_d;
  logic [N_REQ-1:0]  pending_q, pending_d, clr;
  logic [CODE_W-1:0] code_q, code_d, win_idx, start;
  logic              valid_q, valid_d, ovf_q, ovf_d, win_found, hshake;

  assign hshake = valid_q && ready_in;
  assign clr    = hshake ? onehot8(code_q) : '0;

`ifdef ENC83_ROUND_ROBIN_EN
  localparam bit DESC = 1'b0;
  logic [CODE_W-1:0] last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= '1;
    else if (hshake) last_q <= code_q;
  end
  assign start = last_q + CODE_W'(1);
`else
  localparam bit DESC = 1'b1;
  assign start = CODE_W'(N_REQ - 1);
`endif

  prio_find8 #(.DESCEND(DESC)) u_find (
    .vec_i   (pending_q),
    .start_i (start),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  // Set is OR'd after the clear so a coincident request keeps its bit pending.
  assign pending_d = (pending_q & ~clr) | (enable ? req_in : '0);
  assign ovf_d     = enable && |(req_in & pending_q & ~clr);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (enable && win_found) begin
          code_d  = win_idx;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ready_in) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
    end
  end

  assign code_out     = code_q;
  assign valid_out    = valid_q;
  assign pending_out  = pending_q;
  assign overflow_out = ovf_q;
endmodule

// File: tb/tb_encoder83_req.sv
// Self-checking bench for encoder83_req: directed cases plus randomized traffic vs. a behavioural model.
module tb_encoder83_req;
  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ready_in = 1'b0;
  logic [7:0] req_in = '0;
  logic [2:0] code_out;
  logic       valid_out, overflow_out;
  logic [7:0] pending_out;

  int errs = 0, checks = 0;

  encoder83_req dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_in(req_in), .ready_in(ready_in),
    .code_out(code_out), .valid_out(valid_out), .pending_out(pending_out),
    .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] m_pend;
  logic [2:0] m_code, m_last;
  logic       m_valid, m_ovf;

  function automatic logic [2:0] pick(input logic [7:0] p, input logic [2:0] last);
    logic [2:0] r;
    r = 3'd0;
`ifdef ENC83_ROUND_ROBIN_EN
    for (int k = 8; k >= 1; k--)
      if (p[(int'(last) + k) % 8]) r = 3'(( int'(last) + k) % 8);
`else
    for (int i = 0; i < 8; i++) if (p[i]) r = 3'(i);
`endif
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] clrm, newp;
    logic       nov;
    if (!rst_n) begin
      m_pend = '0; m_code = '0; m_valid = 0; m_ovf = 0; m_last = 3'd7;
    end else begin
      clrm = (m_valid && ready_in) ? (8'd1 << m_code) : 8'd0;
      newp = (m_pend & ~clrm) | (enable ? req_in : 8'd0);
      nov  = enable && ((req_in & m_pend & ~clrm) != 0);
      if (m_valid) begin
        if (ready_in) begin m_valid = 0; m_last = m_code; end
      end else if (enable && m_pend != 0) begin
        m_code = pick(m_pend, m_last); m_valid = 1;
      end
      m_pend = newp;
      m_ovf  = nov;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model compare on every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_valid", 32'(valid_out), 32'(m_valid));
      chk("m_pend", 32'(pending_out), 32'(m_pend));
      chk("m_ovf", 32'(overflow_out), 32'(m_ovf));
      if (m_valid) chk("m_code", 32'(code_out), 32'(m_code));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; enable = 1; req_in = '0; ready_in = 0;
    #1;
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_pend", 32'(pending_out), 0);
    chk("rst_code", 32'(code_out), 0);
    chk("rst_ovf", 32'(overflow_out), 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic step(); @(negedge clk); endtask

  logic [2:0] e_first, e_second;

  initial begin
    // 1: single request, ready held high
    do_reset();
    req_in = 8'h01; ready_in = 1;
    step(); req_in = 8'h00;
    chk("t1_pend", 32'(pending_out), 32'h01);
    chk("t1_valid_early", 32'(valid_out), 0);
    step();
    chk("t1_valid", 32'(valid_out), 1);
    chk("t1_code", 32'(code_out), 0);
    step();
    chk("t1_pend_clr", 32'(pending_out), 0);
    chk("t1_valid_off", 32'(valid_out), 0);

    // 2: two requests, bubble between grants
`ifdef ENC83_ROUND_ROBIN_EN
    e_first = 3'd1; e_second = 3'd7;
`else
    e_first = 3'd7; e_second = 3'd1;
`endif
    do_reset();
    req_in = 8'h82; ready_in = 1;
    step(); req_in = 8'h00;
    step();
    chk("t2_v1", 32'(valid_out), 1);
    chk("t2_c1", 32'(code_out), 32'(e_first));
    step();
    chk("t2_bubble", 32'(valid_out), 0);
    step();
    chk("t2_v2", 32'(valid_out), 1);
    chk("t2_c2", 32'(code_out), 32'(e_second));
    step();
    chk("t2_done", 32'(pending_out), 0);

    // 3: hold under back-pressure while new requests arrive
    do_reset();
    req_in = 8'h20; ready_in = 0;
    step(); req_in = 8'h00;
    step();
    for (int i = 0; i < 10; i++) begin
      req_in = (i % 2 == 0) ? 8'h10 : 8'h00;
      step();
    end
    req_in = 8'h00;
    chk("t3_code", 32'(code_out), 5);
    chk("t3_valid", 32'(valid_out), 1);
    chk("t3_pend", 32'(pending_out), 32'h30);
    ready_in = 1;
    repeat (4) step();

    // 4: re-request of a pending bit merges and flags overflow once
    do_reset();
    req_in = 8'h08; ready_in = 0;
    step();
    step(); req_in = 8'h00;
    chk("t4_ovf", 32'(overflow_out), 1);
    chk("t4_code", 32'(code_out), 3);
    step();
    chk("t4_ovf_pulse", 32'(overflow_out), 0);
    ready_in = 1;
    step();
    chk("t4_pend", 32'(pending_out), 0);
    step();
    chk("t4_single", 32'(valid_out), 0);

    // 5: set wins over clear on the handshake edge
    do_reset();
    req_in = 8'h04; ready_in = 0;
    step(); req_in = 8'h00;
    step();
    chk("t5_code", 32'(code_out), 2);
    ready_in = 1; req_in = 8'h04;
    step(); req_in = 8'h00;
    chk("t5_pend", 32'(pending_out), 32'h04);
    chk("t5_ovf", 32'(overflow_out), 0);
    step();
    chk("t5_repres", 32'(valid_out), 1);
    chk("t5_recode", 32'(code_out), 2);
    step();

    // 6: enable low blocks capture, then async reset mid-presentation
    do_reset();
    enable = 0; req_in = 8'hFF;
    repeat (3) step();
    chk("t6_pend", 32'(pending_out), 0);
    chk("t6_valid", 32'(valid_out), 0);
    enable = 1; req_in = 8'h40; ready_in = 0;
    step(); req_in = 8'h00;
    step();
    chk("t6_valid_on", 32'(valid_out), 1);
    #2 rst_n = 0;
    #1;
    chk("t6_arst_valid", 32'(valid_out), 0);
    chk("t6_arst_code", 32'(code_out), 0);
    chk("t6_arst_pend", 32'(pending_out), 0);
    @(negedge clk); rst_n = 1;

    // Randomized traffic checked cycle-by-cycle against the model
    for (int i = 0; i < 3000; i++) begin
      req_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ready_in = ($urandom_range(0, 2) != 0);
      enable   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 0; #1 rst_n = 1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
